// File: rtl/hazard_controller_if.sv
// hazard_controller_if
//   Bundles the pipeline-side signals seen by the hazard controller.
//   master : pipeline datapath (drives register ids, control bits and
//            memory handshake; receives forwarding/stall/flush controls)
//   slave  : hazard_controller
//   Signals:
//     de_rs1/de_rs2        source registers of the instruction in DE
//     ex_rs1/ex_rs2/ex_rd  register ids of the instruction in EX
//     ex_mem_reg           EX instruction is a load
//     mem_rd/mem_de_we     destination and write-enable of MEM instruction
//     wb_rd/wb_de_we       destination and write-enable of WB instruction
//     brn_taken            branch in EX resolved taken
//     dmem_req/dmem_ack    data-memory request from MEM / completion
//     fw_sel1/fw_sel2      EX operand sources (00 regfile, 01 MEM, 10 WB)
//     stall_*/flush_*      pipeline register hold / bubble controls
//     mem_err              one-cycle pulse on data-memory timeout
interface hazard_controller_if;
  logic [4:0] de_rs1;
  logic [4:0] de_rs2;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_reg;
  logic [4:0] mem_rd;
  logic       mem_de_we;
  logic [4:0] wb_rd;
  logic       wb_de_we;
  logic       brn_taken;
  logic       dmem_req;
  logic       dmem_ack;
  logic [1:0] fw_sel1;
  logic [1:0] fw_sel2;
  logic       stall_fe;
  logic       stall_de;
  logic       stall_ex;
  logic       stall_mem;
  logic       flush_de;
  logic       flush_ex;
  logic       flush_wb;
  logic       mem_err;

  modport master (
    output de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_reg,
           mem_rd, mem_de_we, wb_rd, wb_de_we, brn_taken, dmem_req, dmem_ack,
    input  fw_sel1, fw_sel2, stall_fe, stall_de, stall_ex, stall_mem,
           flush_de, flush_ex, flush_wb, mem_err
  );

  modport slave (
    input  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_reg,
           mem_rd, mem_de_we, wb_rd, wb_de_we, brn_taken, dmem_req, dmem_ack,
    output fw_sel1, fw_sel2, stall_fe, stall_de, stall_ex, stall_mem,
           flush_de, flush_ex, flush_wb, mem_err
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller
//   Sequencing controller for a 5-stage RISC-V pipeline: operand
//   forwarding selects, load-use bubble, taken-branch flush and a
//   two-state FSM (RUN / MEM_WAIT) for multi-cycle data-memory accesses
//   with a timeout abort.
//   Ports:
//     clk  core clock, rising edge
//     rst  asynchronous active-high reset; forces every output to 0
//     hif  hazard_controller_if.slave (see interface file for signals)
//   Parameter:
//     MEM_TIMEOUT  max cycles spent in MEM_WAIT before abort (>= 2)
//   Optional build macro HAZARD_PERF_CNT_EN adds 32-bit wrapping
//   counters stall_cycles, flush_events and load_use_events.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_events,
  output logic [31:0]        load_use_events
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Forwarding for both EX operands; MEM result has priority over WB, x0 never forwarded.
  logic [4:0] ex_rs [2];
  logic [1:0] fw_sel [2];
  assign ex_rs[0] = hif.ex_rs1;
  assign ex_rs[1] = hif.ex_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        if (hif.mem_de_we && (hif.mem_rd != 5'd0) && (hif.mem_rd == ex_rs[gi]))
          fw_sel[gi] = 2'b01;
        else if (hif.wb_de_we && (hif.wb_rd != 5'd0) && (hif.wb_rd == ex_rs[gi]))
          fw_sel[gi] = 2'b10;
        else
          fw_sel[gi] = 2'b00;
      end
    end
  endgenerate

  logic load_use;
  assign load_use = hif.ex_mem_reg && (hif.ex_rd != 5'd0) &&
                    ((hif.ex_rd == hif.de_rs1) || (hif.ex_rd == hif.de_rs2));

  logic stall_all, stall_front, flush_de_c, flush_ex_c, flush_wb_c, mem_err_c;
  logic brn_act, load_use_act;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    stall_all    = 1'b0;
    stall_front  = 1'b0;
    flush_de_c   = 1'b0;
    flush_ex_c   = 1'b0;
    flush_wb_c   = 1'b0;
    mem_err_c    = 1'b0;
    brn_act      = 1'b0;
    load_use_act = 1'b0;
    if (state_reg == ST_RUN) begin
      if (hif.dmem_req && !hif.dmem_ack) begin
        // The whole pipe freezes while the access is outstanding; WB gets a bubble.
        stall_all  = 1'b1;
        flush_wb_c = 1'b1;
        cnt_next   = '0;
        state_next = ST_MEM_WAIT;
      end else if (hif.brn_taken) begin
        // The wrong-path instruction in DE is squashed, so its load-use hazard is moot.
        flush_de_c = 1'b1;
        flush_ex_c = 1'b1;
        brn_act    = 1'b1;
      end else if (load_use) begin
        stall_front  = 1'b1;
        flush_ex_c   = 1'b1;
        load_use_act = 1'b1;
      end
    end else begin
      // EX is frozen here, so branch / load-use are simply re-seen after return.
      if (hif.dmem_ack) begin
        cnt_next   = '0;
        state_next = ST_RUN;
      end else if (cnt_reg == CNT_MAX) begin
        // Abort: release the pipe but discard the faulting access.
        mem_err_c  = 1'b1;
        flush_wb_c = 1'b1;
        cnt_next   = '0;
        state_next = ST_RUN;
      end else begin
        stall_all  = 1'b1;
        flush_wb_c = 1'b1;
        cnt_next   = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs are gated by rst so they drop immediately, not at the next edge.
  assign hif.fw_sel1   = rst ? 2'b00 : fw_sel[0];
  assign hif.fw_sel2   = rst ? 2'b00 : fw_sel[1];
  assign hif.stall_fe  = !rst && (stall_all || stall_front);
  assign hif.stall_de  = !rst && (stall_all || stall_front);
  assign hif.stall_ex  = !rst && stall_all;
  assign hif.stall_mem = !rst && stall_all;
  assign hif.flush_de  = !rst && flush_de_c;
  assign hif.flush_ex  = !rst && flush_ex_c;
  assign hif.flush_wb  = !rst && flush_wb_c;
  assign hif.mem_err   = !rst && mem_err_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg, flush_events_reg, load_use_events_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg    <= '0;
      flush_events_reg    <= '0;
      load_use_events_reg <= '0;
    end else begin
      if (stall_all || stall_front) stall_cycles_reg    <= stall_cycles_reg + 32'd1;
      if (brn_act)                  flush_events_reg    <= flush_events_reg + 32'd1;
      if (load_use_act)             load_use_events_reg <= load_use_events_reg + 32'd1;
    end
  end

  assign stall_cycles    = stall_cycles_reg;
  assign flush_events    = flush_events_reg;
  assign load_use_events = load_use_events_reg;
`else
  // Event strobes only feed the optional counters.
  logic unused_events;
  assign unused_events = brn_act ^ load_use_act;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed tests for hazard_controller with MEM_TIMEOUT=4. Each task
//   drives one scenario and compares the packed output vector
//   {fw_sel1, fw_sel2, stall_fe, stall_de, stall_ex, stall_mem,
//    flush_de, flush_ex, flush_wb, mem_err} against hand-computed values.
//   Inputs change 1 ns after the rising edge, checks happen 1 ns later.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hazard_controller_if hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, load_use_events;
`endif

  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {hif.fw_sel1, hif.fw_sel2, hif.stall_fe, hif.stall_de, hif.stall_ex,
            hif.stall_mem, hif.flush_de, hif.flush_ex, hif.flush_wb, hif.mem_err};
  endfunction

  task automatic clear_inputs();
    hif.de_rs1 = 5'd0; hif.de_rs2 = 5'd0; hif.ex_rs1 = 5'd0; hif.ex_rs2 = 5'd0;
    hif.ex_rd = 5'd0; hif.ex_mem_reg = 1'b0; hif.mem_rd = 5'd0; hif.mem_de_we = 1'b0;
    hif.wb_rd = 5'd0; hif.wb_de_we = 1'b0; hif.brn_taken = 1'b0;
    hif.dmem_req = 1'b0; hif.dmem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    // Inputs that would otherwise forward, stall and flush.
    hif.ex_mem_reg = 1'b1; hif.ex_rd = 5'd5; hif.de_rs1 = 5'd5;
    hif.mem_rd = 5'd7; hif.mem_de_we = 1'b1; hif.ex_rs1 = 5'd7;
    hif.dmem_req = 1'b1;
    #3;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL reset_outputs: got %b expected %b", got, 13'b0);
    end else $display("reset_outputs: %b", got);
    tick(); tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL idle_after_reset: got %b expected %b", got, 13'b0);
    end else $display("idle_after_reset: %b", got);
  endtask

  task automatic test_load_use();
    logic [12:0] got, exp;
    tick();
    hif.ex_mem_reg = 1'b1; hif.ex_rd = 5'd5; hif.de_rs1 = 5'd5;
    #1;
    exp = {2'b00, 2'b00, 4'b1100, 3'b010, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL load_use_bubble: got %b expected %b", got, exp);
    end else $display("load_use_bubble: %b", got);
    // Load moves to MEM, dependent instruction now in EX.
    tick();
    clear_inputs();
    hif.mem_rd = 5'd5; hif.mem_de_we = 1'b1; hif.ex_rs1 = 5'd5;
    #1;
    exp = {2'b01, 2'b00, 4'b0000, 3'b000, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL load_use_forward: got %b expected %b", got, exp);
    end else $display("load_use_forward: %b", got);
    // Load to x0 via rs2 is not a hazard.
    tick();
    clear_inputs();
    hif.ex_mem_reg = 1'b1; hif.ex_rd = 5'd0; hif.de_rs2 = 5'd0;
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL load_x0_no_stall: got %b expected %b", got, 13'b0);
    end else $display("load_x0_no_stall: %b", got);
    // rs2 match also triggers the bubble.
    tick();
    hif.ex_rd = 5'd9; hif.de_rs2 = 5'd9; hif.de_rs1 = 5'd1;
    #1;
    exp = {2'b00, 2'b00, 4'b1100, 3'b010, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL load_use_rs2: got %b expected %b", got, exp);
    end else $display("load_use_rs2: %b", got);
    clear_inputs();
  endtask

  task automatic test_forwarding();
    logic [12:0] got, exp;
    tick();
    hif.mem_rd = 5'd3; hif.wb_rd = 5'd3; hif.mem_de_we = 1'b1; hif.wb_de_we = 1'b1;
    hif.ex_rs2 = 5'd3; hif.ex_rs1 = 5'd7;
    #1;
    exp = {2'b00, 2'b01, 4'b0000, 3'b000, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL fwd_mem_beats_wb: got %b expected %b", got, exp);
    end else $display("fwd_mem_beats_wb: %b", got);
    tick();
    hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; hif.ex_rs2 = 5'd0;
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL fwd_x0_never: got %b expected %b", got, 13'b0);
    end else $display("fwd_x0_never: %b", got);
    tick();
    hif.mem_rd = 5'd3; hif.mem_de_we = 1'b0; hif.wb_rd = 5'd3; hif.wb_de_we = 1'b1;
    hif.ex_rs1 = 5'd3; hif.ex_rs2 = 5'd3;
    #1;
    exp = {2'b10, 2'b10, 4'b0000, 3'b000, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL fwd_wb_only: got %b expected %b", got, exp);
    end else $display("fwd_wb_only: %b", got);
    clear_inputs();
  endtask

  task automatic test_branch();
    logic [12:0] got, exp;
    tick();
    hif.brn_taken = 1'b1;
    hif.ex_mem_reg = 1'b1; hif.ex_rd = 5'd5; hif.de_rs1 = 5'd5;
    #1;
    exp = {2'b00, 2'b00, 4'b0000, 3'b110, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL branch_over_load_use: got %b expected %b", got, exp);
    end else $display("branch_over_load_use: %b", got);
    // Both DE and EX were flushed: bubble in EX, no further action.
    tick();
    clear_inputs();
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL branch_no_followup: got %b expected %b", got, 13'b0);
    end else $display("branch_no_followup: %b", got);
  endtask

  task automatic test_dmem_wait();
    logic [12:0] got, exp;
    exp = {2'b00, 2'b00, 4'b1111, 3'b001, 1'b0};
    tick();
    hif.dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      // A taken branch during the wait must be ignored.
      hif.brn_taken = (c == 2);
      #1;
      got = outs();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL dmem_stall_c%0d: got %b expected %b", c, got, exp);
      end else $display("dmem_stall_c%0d: %b", c, got);
      tick();
    end
    hif.brn_taken = 1'b0;
    hif.dmem_ack = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL dmem_ack_release: got %b expected %b", got, 13'b0);
    end else $display("dmem_ack_release: %b", got);
    tick();
    clear_inputs();
    hif.brn_taken = 1'b1;
    #1;
    exp = {2'b00, 2'b00, 4'b0000, 3'b110, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL dmem_back_in_run: got %b expected %b", got, exp);
    end else $display("dmem_back_in_run: %b", got);
    clear_inputs();
  endtask

  task automatic test_timeout(input logic late_ack);
    logic [12:0] got, exp;
    exp = {2'b00, 2'b00, 4'b1111, 3'b001, 1'b0};
    tick();
    hif.dmem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      got = outs();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL timeout_stall_a%0d_c%0d: got %b expected %b", late_ack, c, got, exp);
      end else $display("timeout_stall_a%0d_c%0d: %b", late_ack, c, got);
      tick();
    end
    hif.dmem_ack = late_ack;
    #1;
    exp = late_ack ? 13'b0 : {2'b00, 2'b00, 4'b0000, 3'b001, 1'b1};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL timeout_edge_a%0d: got %b expected %b", late_ack, got, exp);
    end else $display("timeout_edge_a%0d: %b", late_ack, got);
    tick();
    clear_inputs();
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL timeout_after_a%0d: got %b expected %b", late_ack, got, 13'b0);
    end else $display("timeout_after_a%0d: %b", late_ack, got);
  endtask

  task automatic test_reset_mid_wait();
    logic [12:0] got, exp;
    tick();
    hif.dmem_req = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL async_reset_drop: got %b expected %b", got, 13'b0);
    end else $display("async_reset_drop: %b", got);
    tick();
    clear_inputs();
    rst = 1'b0;
    hif.brn_taken = 1'b1;
    #1;
    exp = {2'b00, 2'b00, 4'b0000, 3'b110, 1'b0};
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_to_run: got %b expected %b", got, exp);
    end else $display("reset_to_run: %b", got);
    tick();
    clear_inputs();
    hif.dmem_req = 1'b1; hif.dmem_ack = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL single_cycle_access: got %b expected %b", got, 13'b0);
    end else $display("single_cycle_access: %b", got);
    tick();
    clear_inputs();
    #1;
    got = outs();
    checks++;
    if (got !== 13'b0) begin
      failures++; $display("FAIL single_cycle_idle: got %b expected %b", got, 13'b0);
    end else $display("single_cycle_idle: %b", got);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_dmem_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core (FE/DE/EX/MEM/WB).
- Consumes decode control bits (DE_WE, MEM_REG, MEM_WE, BRN_COND outcome) carried down the pipe.
- Generates forwarding selects, stall/flush controls and data-memory wait sequencing.
- Holds a small FSM for multi-cycle data-memory access with timeout; everything else resolves in the same cycle.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before abort (>=2)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
de_rs1  in  5  rs1 of instruction in DE
de_rs2  in  5  rs2 of instruction in DE
ex_rs1  in  5  rs1 of instruction in EX
ex_rs2  in  5  rs2 of instruction in EX
ex_rd  in  5  rd of instruction in EX
ex_mem_reg  in  1  EX instruction is a load
mem_rd  in  5  rd in MEM
mem_de_we  in  1  MEM instruction writes regfile
wb_rd  in  5  rd in WB
wb_de_we  in  1  WB instruction writes regfile
brn_taken  in  1  branch in EX resolved taken
dmem_req  in  1  MEM instruction accesses data memory (load or store)
dmem_ack  in  1  data memory completes access this cycle
fw_sel1  out  2  EX operand 1 source: 00 regfile, 01 MEM result, 10 WB result
fw_sel2  out  2  EX operand 2 source, same encoding
stall_fe  out  1  hold PC / FE register
stall_de  out  1  hold DE register
stall_ex  out  1  hold EX register
stall_mem  out  1  hold MEM register
flush_de  out  1  insert bubble into DE register
flush_ex  out  1  insert bubble into EX register
flush_wb  out  1  insert bubble into WB register
mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- One clock (clk); rst asynchronous, active-high. Under reset: state=RUN, timeout counter=0, mem_err=0; all outputs 0.
- Forwarding (combinational, all states): fw_sel1=01 if mem_de_we && mem_rd!=0 && mem_rd==ex_rs1; else 10 if wb_de_we && wb_rd!=0 && wb_rd==ex_rs1; else 00. MEM beats WB. fw_sel2 is identical using ex_rs2. x0 is never forwarded.
- States:
  - RUN: normal flow.
  - MEM_WAIT: data memory outstanding.
- RUN, priority high to low:
  1. dmem_req && !dmem_ack:
     - Go to MEM_WAIT next cycle.
     - This cycle: stall_fe=stall_de=stall_ex=stall_mem=1, flush_wb=1; no other flush.
  2. brn_taken: flush_de=flush_ex=1 for 1 cycle; no stall. Suppresses any load-use stall this cycle.
  3. Load-use: ex_mem_reg && ex_rd!=0 && (ex_rd==de_rs1 || ex_rd==de_rs2).
     - stall_fe=stall_de=1, flush_ex=1 for exactly 1 cycle (one bubble).
     - Next cycle the load is in MEM and resolves via fw 01.
  4. Else: all stall/flush 0.
- dmem_req && dmem_ack in RUN is a single-cycle access: no stall.
- MEM_WAIT:
  - stall_fe/de/ex/mem=1 and flush_wb=1 every cycle; brn_taken and load-use are ignored.
  - EX is frozen, so a pending branch or load-use is re-evaluated after return.
  - Counter increments each MEM_WAIT cycle.
  - dmem_ack=1: that cycle stalls are released (MEM result valid), flush_wb=0, counter cleared, go to RUN.
  - Counter reaches MEM_TIMEOUT-1 without ack: mem_err=1 for that one cycle, stalls released, flush_wb=1 (faulting access is discarded), counter cleared, go to RUN.
  - ack and timeout in the same cycle: ack wins, no mem_err.
- Reset asserted in MEM_WAIT returns immediately to RUN with all outputs 0.
- mem_err is registered-free combinational from state+counter; asserted only in MEM_WAIT.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds 32-bit outputs stall_cycles, flush_events, load_use_events, each reset to 0 by rst and wrapping at 2^32.
  - stall_cycles: +1 every cycle stall_fe=1.
  - flush_events: +1 per cycle with brn_taken acted on.
  - load_use_events: +1 per load-use bubble.
- Undefined: ports and registers absent; remaining behaviour identical.

Test Plan:
- Load x5 in EX, DE reads rs1=5: stall_fe=stall_de=flush_ex=1 for exactly 1 cycle. Next cycle fw_sel1=01.
- mem_rd=3, wb_rd=3, both we, ex_rs2=3: fw_sel2=01. Same with mem_rd=0 and wb_rd=0: fw_sel2=00.
- brn_taken=1 together with a load-use hazard: flush_de=flush_ex=1, stall_fe=0, no bubble in the following cycle.
- dmem_req=1 with ack delayed 3 cycles: all stalls and flush_wb=1 for 3 cycles. On the ack cycle stalls=0, flush_wb=0; state RUN.
- MEM_TIMEOUT=4, dmem_req with no ack: mem_err pulses in the 4th cycle after the request cycle, then RUN with stalls 0. Ack arriving in that same cycle gives mem_err=0.
- rst asserted mid-MEM_WAIT: outputs drop to 0 asynchronously. After release, a dmem_req with immediate ack causes no stall.
